uart_rx_fifo_ctrl: RTL

//  Memory-mapped UART receiver: 8N1 deserializer plus receive FIFO on the CPU clock.
//  The bus drives ren and address[1:0]; this block returns data_out, which the bus muxes as uart_out.
//  rx_irq is a level interrupt for the CPU's external-interrupt path.

---
 rtl/uart_rx_fifo_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - 8N1 UART receiver with receive FIFO and bus register interface
module uart_rx_fifo_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic        ren,
    input  logic [1:0]  address,
    output logic [31:0] data_out,
    output logic        rx_irq
);

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   push;
    logic                   frame_err_set;

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]          count_q, count_d;
    logic                   empty, full;
    logic                   push_ok, pop_ok, overrun_set;
    logic                   overrun_q, frame_err_q;
    logic                   ren_q;
    logic                   access, pop_req, status_clr;
    logic [7:0]             head_byte;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = CW'(HALF - 1);
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        state_d = S_DATA;
                        cnt_d   = CW'(DIV - 1);
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = CW'(DIV - 1);
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) must not spawn back-to-back frames.
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ren_q <= 1'b0;
        end else begin
            ren_q <= ren;
        end
    end

    assign access     = ren & ~ren_q;
    assign pop_req    = access & (address == 2'd0);
    assign status_clr = access & (address == 2'd1);

    assign empty       = (count_q == '0);
    assign full        = (count_q == NW'(FIFO_DEPTH));
    assign pop_ok      = pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok     = push & (~full | pop_ok);
    assign overrun_set = push & full & ~pop_ok;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q     <= count_d;
            overrun_q   <= overrun_set | (overrun_q & ~status_clr);
            frame_err_q <= frame_err_set | (frame_err_q & ~status_clr);
        end
    end

    assign head_byte = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        data_out = 32'h0;
        case (address)
            2'd0:    data_out = {23'b0, ~empty, head_byte};
            2'd1:    data_out = {28'b0, frame_err_q, overrun_q, full, ~empty};
            2'd2:    data_out = {{(32 - NW){1'b0}}, count_q};
            default: data_out = 32'h0;
        endcase
    end

    assign rx_irq = ~empty;

endmodule
